// File: rtl/instr_fetch_stage_if.sv
// Fetch stage bus: pipeline control in, ROM address/data, IF/ID and trap outputs out.
// Latency: pure wiring bundle, no storage.
// Backpressure: stall/flush arrive as levels from decode/execute; no handshake.
//
// Signals:
//   stall, flush                    hazard hold / IF/ID invalidate from decode/execute
//   redirect_valid/target/is_jr     branch or jump redirect request
//   irq, exc                        level interrupt request, undefined-instruction exception
//   rom_addr / rom_data             word address to ROM, combinational instruction back
//   pc                              current program counter
//   if_id_instr/pc_plus4/valid      IF/ID pipeline register contents
//   trap_epc, trap_taken            trap return address and one-cycle accept pulse
// Modports: master = pipeline/ROM side driving requests, slave = the fetch stage.
interface instr_fetch_stage_if;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        redirect_is_jr;
  logic        irq;
  logic        exc;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic [31:0] trap_epc;
  logic        trap_taken;

  modport slave (
    input  stall, flush, redirect_valid, redirect_target, redirect_is_jr,
    input  irq, exc, rom_data,
    output rom_addr, pc, if_id_instr, if_id_pc_plus4, if_id_valid,
    output trap_epc, trap_taken
  );

  modport master (
    output stall, flush, redirect_valid, redirect_target, redirect_is_jr,
    output irq, exc, rom_data,
    input  rom_addr, pc, if_id_instr, if_id_pc_plus4, if_id_valid,
    input  trap_epc, trap_taken
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// Instruction fetch: owns the PC, addresses the ROM, captures the instruction into IF/ID.
// Latency: rom_data for pc lands in if_id_instr one edge later; one fetch per cycle.
// Backpressure: stall holds PC and IF/ID; traps override stall and flush.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    instr_fetch_stage_if.slave (control in, ROM address/data, IF/ID and trap out)
// PC[31] is the kernel-mode bit; interrupts are masked while it is set.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter logic [31:0] IRQ_VECTOR = 32'h8000_0004,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0008
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_fetch_stage_if.slave   bus
);

  logic [31:0] r_pc;
  logic [31:0] r_if_id_instr;
  logic [31:0] r_if_id_pc_plus4;
  logic        r_if_id_valid;
  logic [31:0] r_trap_epc;
  logic        r_trap_taken;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_redirect_pc;
  logic        w_irq_take;
  logic        w_trap;

  always_comb begin
    // The mode bit never takes a carry: the address space wraps within bits 30:0.
    w_pc_plus4    = {r_pc[31], r_pc[30:0] + 31'd4};
    // Only jr/jalr may change privilege; other redirects keep the current mode.
    w_redirect_pc = bus.redirect_is_jr ? bus.redirect_target
                                       : {r_pc[31], bus.redirect_target[30:0]};
    w_irq_take    = bus.irq & ~r_pc[31];
    w_trap        = bus.exc | w_irq_take;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc             <= RESET_PC;
      r_if_id_instr    <= 32'd0;
      r_if_id_pc_plus4 <= 32'd0;
      r_if_id_valid    <= 1'b0;
      r_trap_epc       <= 32'd0;
      r_trap_taken     <= 1'b0;
    end else begin
      r_trap_taken <= w_trap;
      if (bus.exc) begin
        // Faulting instruction sits in IF/ID; return past it.
        r_pc          <= EXC_VECTOR;
        r_trap_epc    <= r_if_id_pc_plus4;
        r_if_id_valid <= 1'b0;
      end else if (w_irq_take) begin
        // The instruction at pc was never fetched, so it is re-executed on return.
        r_pc          <= IRQ_VECTOR;
        r_trap_epc    <= r_pc;
        r_if_id_valid <= 1'b0;
      end else begin
        if (bus.redirect_valid) begin
          r_pc <= w_redirect_pc;
        end else if (!bus.stall) begin
          r_pc <= w_pc_plus4;
        end

        if (bus.flush) begin
          r_if_id_valid <= 1'b0;
          if (!bus.stall) begin
            r_if_id_instr <= 32'd0;
          end
        end else if (!bus.stall) begin
          // Redirect still captures the current word (delay slot); decode squashes via flush.
          r_if_id_instr    <= bus.rom_data;
          r_if_id_pc_plus4 <= w_pc_plus4;
          r_if_id_valid    <= 1'b1;
        end
      end
    end
  end

  assign bus.rom_addr       = r_pc;
  assign bus.pc             = r_pc;
  assign bus.if_id_instr    = r_if_id_instr;
  assign bus.if_id_pc_plus4 = r_if_id_pc_plus4;
  assign bus.if_id_valid    = r_if_id_valid;
  assign bus.trap_epc       = r_trap_epc;
  assign bus.trap_taken     = r_trap_taken;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: vector table driven one edge per entry through a scoreboard.
// Latency: each vector is checked #1 after the edge it was applied to.
// Backpressure: stall/flush exercised as table entries.
module tb_instr_fetch_stage;

  logic clk;
  logic reset;
  instr_fetch_stage_if bus ();

  instr_fetch_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {16'hC0DE, 10'd0, a[7:2]};
  endfunction

  assign bus.rom_data = rom_word(bus.rom_addr);

  // ctl = {stall, flush, redirect_valid, redirect_is_jr, irq, exc}
  typedef struct packed {
    logic [5:0]  ctl;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic        e_valid;
    logic        e_trap;
    logic        c_instr;
    logic [31:0] e_instr;
    logic        c_pp4;
    logic [31:0] e_pp4;
    logic        c_epc;
    logic [31:0] e_epc;
  } vec_t;

  localparam logic [5:0] IDLE = 6'b000000;
  localparam logic [5:0] STL  = 6'b100000;
  localparam logic [5:0] FL   = 6'b010000;
  localparam logic [5:0] RV   = 6'b001000;
  localparam logic [5:0] JR   = 6'b001100;
  localparam logic [5:0] IRQ  = 6'b000010;
  localparam logic [5:0] EXC  = 6'b000001;

  int total = 0;
  int bad   = 0;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(input logic [5:0] ctl, input logic [31:0] tgt,
                              input logic [31:0] pc, input logic v, input logic t,
                              input logic ci, input logic [31:0] instr,
                              input logic cp, input logic [31:0] pp4,
                              input logic ce, input logic [31:0] epc);
    vec_t r;
    r.ctl = ctl; r.tgt = tgt; r.e_pc = pc; r.e_valid = v; r.e_trap = t;
    r.c_instr = ci; r.e_instr = instr; r.c_pp4 = cp; r.e_pp4 = pp4;
    r.c_epc = ce; r.e_epc = epc;
    return r;
  endfunction

  task automatic check(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic check_vec(input int idx, input vec_t e);
    check("pc", idx, bus.pc, e.e_pc);
    check("rom_addr", idx, bus.rom_addr, e.e_pc);
    check("valid", idx, {31'd0, bus.if_id_valid}, {31'd0, e.e_valid});
    check("trap_taken", idx, {31'd0, bus.trap_taken}, {31'd0, e.e_trap});
    if (e.c_instr) check("instr", idx, bus.if_id_instr, e.e_instr);
    if (e.c_pp4)   check("pc_plus4", idx, bus.if_id_pc_plus4, e.e_pp4);
    if (e.c_epc)   check("trap_epc", idx, bus.trap_epc, e.e_epc);
  endtask

  task automatic check_reset(input int idx);
    check("rst_pc", idx, bus.pc, 32'h8000_0000);
    check("rst_instr", idx, bus.if_id_instr, 32'd0);
    check("rst_pp4", idx, bus.if_id_pc_plus4, 32'd0);
    check("rst_valid", idx, {31'd0, bus.if_id_valid}, 32'd0);
    check("rst_epc", idx, bus.trap_epc, 32'd0);
    check("rst_trap", idx, {31'd0, bus.trap_taken}, 32'd0);
  endtask

  task automatic drive(input vec_t v);
    {bus.stall, bus.flush, bus.redirect_valid, bus.redirect_is_jr, bus.irq, bus.exc} = v.ctl;
    bus.redirect_target = v.tgt;
  endtask

  initial begin
    vec_t e;
    // ctl, tgt, pc, valid, trap, c_instr, instr, c_pp4, pp4, c_epc, epc
    tbl.push_back(mk(IDLE, 0, 32'h8000_0004, 1, 0, 1, rom_word(32'h8000_0000), 1, 32'h8000_0004, 1, 0));
    tbl.push_back(mk(IDLE, 0, 32'h8000_0008, 1, 0, 1, rom_word(32'h8000_0004), 1, 32'h8000_0008, 0, 0));
    tbl.push_back(mk(JR, 32'h10, 32'h10, 1, 0, 1, rom_word(32'h8000_0008), 1, 32'h8000_000C, 0, 0));
    tbl.push_back(mk(IDLE, 0, 32'h14, 1, 0, 1, rom_word(32'h10), 1, 32'h14, 0, 0));
    tbl.push_back(mk(IDLE, 0, 32'h18, 1, 0, 1, rom_word(32'h14), 1, 32'h18, 0, 0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(STL, 0, 32'h18, 1, 0, 1, rom_word(32'h14), 1, 32'h18, 0, 0));
    tbl.push_back(mk(IDLE, 0, 32'h1C, 1, 0, 1, rom_word(32'h18), 1, 32'h1C, 0, 0));
    tbl.push_back(mk(IDLE, 0, 32'h20, 1, 0, 1, rom_word(32'h1C), 1, 32'h20, 0, 0));
    tbl.push_back(mk(IDLE, 0, 32'h24, 1, 0, 1, rom_word(32'h20), 1, 32'h24, 0, 0));
    tbl.push_back(mk(IRQ, 0, 32'h8000_0004, 0, 1, 0, 0, 0, 0, 1, 32'h24));
    tbl.push_back(mk(IDLE, 0, 32'h8000_0008, 1, 0, 1, rom_word(32'h8000_0004), 1, 32'h8000_0008, 1, 32'h24));
    tbl.push_back(mk(IRQ, 0, 32'h8000_000C, 1, 0, 0, 0, 0, 0, 1, 32'h24));
    tbl.push_back(mk(JR, 32'h8000_0100, 32'h8000_0100, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(IRQ, 0, 32'h8000_0104, 1, 0, 0, 0, 0, 0, 1, 32'h24));
    tbl.push_back(mk(JR, 32'h40, 32'h40, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(RV, 32'h8000_000C, 32'h0000_000C, 1, 0, 1, rom_word(32'h40), 1, 32'h44, 0, 0));
    tbl.push_back(mk(JR, 32'h40, 32'h40, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(JR, 32'h8000_000C, 32'h8000_000C, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(JR, 32'h7FFF_FFFC, 32'h7FFF_FFFC, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(IDLE, 0, 32'h0000_0000, 1, 0, 1, rom_word(32'h7FFF_FFFC), 1, 32'h0000_0000, 0, 0));
    tbl.push_back(mk(JR, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(IDLE, 0, 32'h8000_0000, 1, 0, 1, rom_word(32'hFFFF_FFFC), 1, 32'h8000_0000, 0, 0));
    tbl.push_back(mk(FL, 0, 32'h8000_0004, 0, 0, 1, 32'd0, 0, 0, 0, 0));
    tbl.push_back(mk(FL | STL, 0, 32'h8000_0004, 0, 0, 1, 32'd0, 0, 0, 0, 0));
    tbl.push_back(mk(IDLE, 0, 32'h8000_0008, 1, 0, 1, rom_word(32'h8000_0004), 1, 32'h8000_0008, 0, 0));
    tbl.push_back(mk(JR, 32'h2C, 32'h2C, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(IDLE, 0, 32'h30, 1, 0, 1, rom_word(32'h2C), 1, 32'h30, 0, 0));
    tbl.push_back(mk(EXC | IRQ | JR, 32'h100, 32'h8000_0008, 0, 1, 0, 0, 0, 0, 1, 32'h30));
    tbl.push_back(mk(IRQ, 0, 32'h8000_000C, 1, 0, 1, rom_word(32'h8000_0008), 1, 32'h8000_000C, 1, 32'h30));
    tbl.push_back(mk(EXC | STL | FL, 0, 32'h8000_0008, 0, 1, 0, 0, 0, 0, 1, 32'h8000_000C));

    // Reset held low three cycles.
    reset = 1'b0;
    drive(mk(IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) @(posedge clk);
    #1;
    check_reset(-1);
    check("rst_rom_addr", -1, bus.rom_addr, 32'h8000_0000);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      sb.push_back(tbl[i]);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard step %0d: queue empty", i);
      end else begin
        e = sb.pop_front();
        check_vec(i, e);
      end
    end

    // Reset asserted mid-trap pulse with stall held: state clears without a clock edge.
    drive(mk(STL, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    reset = 1'b0;
    #1;
    check_reset(100);
    @(posedge clk);
    #1;
    check_reset(101);
    reset = 1'b1;
    drive(mk(IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    sb.push_back(mk(IDLE, 0, 32'h8000_0004, 1, 0, 1, rom_word(32'h8000_0000), 1, 32'h8000_0004, 1, 32'd0));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_vec(102, e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
